// File: rtl/srt4_div_arbiter.sv
// srt4_div_arbiter: shares one SRT4 radix-4 divider between NREQ requesters.
// Round-robin grant, operand capture, divider handshake sequencing, tagged
// response channel with backpressure, and a watchdog that flushes a hung divider.
module srt4_div_arbiter #(
    parameter int WID     = 8,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*WID-1:0] req_dividend,
    input  logic [NREQ*WID-1:0] req_divisor,
    output logic                div_valid,
    output logic [WID-1:0]      div_dividend,
    output logic [WID-1:0]      div_divisor,
    output logic                div_flush,
    input  logic                div_ready,
    input  logic [WID-1:0]      div_quotient,
    input  logic [WID-1:0]      div_remainder,
    input  logic                div_error,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [WID-1:0]      rsp_quotient,
    output logic [WID-1:0]      rsp_remainder,
    output logic                rsp_error,
    output logic                rsp_timeout
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [WID-1:0]  dvd_q, dvd_d;
    logic [WID-1:0]  dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            div_valid_q, div_valid_d;
    logic            div_flush_q, div_flush_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [WID-1:0]  quo_q, quo_d;
    logic [WID-1:0]  rem_q, rem_d;
    logic            err_q, err_d;
    logic            tmo_q, tmo_d;

    // Unpacked views of the flattened operand buses, one entry per requester.
    logic [WID-1:0]  opa [NREQ];
    logic [WID-1:0]  opb [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign opa[i] = req_dividend[i*WID +: WID];
        assign opb[i] = req_divisor[i*WID +: WID];
    end

    logic            gnt_any;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   cand;
    int              idx;

    // Round-robin search: first set request starting just above the last grant.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx  = (int'(ptr_q) + k) % NREQ;
            cand = PW'(idx);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Accept pulse is combinational in IDLE; held low while reset is asserted.
    always_comb begin
        req_ready = '0;
        // NOTE: reset is folded in here because this output is not a flop and must read 0 during reset.
        if (rst && state_q == S_IDLE && gnt_any) begin
            req_ready = NREQ'(1) << gnt_idx;
        end
    end

    // Next-state and next-register computation for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        div_valid_d = 1'b0;
        div_flush_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        err_d       = err_q;
        tmo_d       = tmo_q;

        unique case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    dvd_d       = opa[gnt_idx];
                    dvs_d       = opb[gnt_idx];
                    ptr_d       = IDW'(gnt_idx);
                    id_d        = IDW'(gnt_idx);
                    div_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (div_ready || div_error) begin
                    quo_d       = div_error ? '0 : div_quotient;
                    rem_d       = div_error ? '0 : div_remainder;
                    err_d       = div_error;
                    tmo_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    quo_d       = '0;
                    rem_d       = '0;
                    err_d       = 1'b0;
                    tmo_d       = 1'b1;
                    div_flush_d = 1'b1;
                    state_d     = S_FLUSH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FLUSH: begin
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State, operand and response registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            id_q        <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            div_valid_q <= 1'b0;
            div_flush_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            div_valid_q <= div_valid_d;
            div_flush_q <= div_flush_d;
            rsp_valid_q <= rsp_valid_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign div_valid     = div_valid_q;
    assign div_flush     = div_flush_q;
    assign div_dividend  = dvd_q;
    assign div_divisor   = dvs_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = id_q;
    assign rsp_quotient  = quo_q;
    assign rsp_remainder = rem_q;
    assign rsp_error     = err_q;
    assign rsp_timeout   = tmo_q;

endmodule
